router_port_rx: RTL and testbench

- Parametrised per-port serial frame receiver for the router input side, replicated NUM_PORTS times.
- Each channel deserialises the router serial protocol (address bits, pad cycles, then payload bits) into parallel words with a destination tag.
- Words are presented on a per-port valid/ready interface to the downstream switch fabric.
- Adds configurable widths and pad length, backpressure via busy_n, and sticky protocol and overflow error flags.

---
 rtl/router_port_rx.sv | 206 ++++++++++++++++++++
 tb/tb_router_port_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_rx.sv
// Per-port serial frame receiver: deserialises address/pad/payload frames into
// parallel words with a destination tag and presents them on valid/ready.
module router_port_rx #(
  parameter int unsigned NUM_PORTS  = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PAD_CYCLES = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          frame_n,
  input  logic [NUM_PORTS-1:0]          valid_n,
  input  logic [NUM_PORTS-1:0]          din,
  output logic [NUM_PORTS-1:0]          busy_n,
  output logic [NUM_PORTS-1:0]          word_valid,
  input  logic [NUM_PORTS-1:0]          word_ready,
  output logic [NUM_PORTS*DATA_W-1:0]   word_data,
  output logic [NUM_PORTS*ADDR_W-1:0]   word_dst,
  output logic [NUM_PORTS-1:0]          word_sop,
  output logic [NUM_PORTS-1:0]          word_eop,
  input  logic                          err_clr,
  output logic [NUM_PORTS-1:0]          err_proto,
  output logic [NUM_PORTS-1:0]          err_ovf
);

  localparam int unsigned MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned MAX_CNT = (MAX_AD > PAD_CYCLES) ? MAX_AD : PAD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_PAD  = 2'd2,
    S_DATA = 2'd3
  } state_e;

  for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_port
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                first_q, first_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                busy_n_q, busy_n_d;
    logic                err_proto_q, err_proto_d;
    logic                err_ovf_q, err_ovf_d;
    logic                done_c, last_c, proto_c;
    logic [DATA_W-1:0]   word_c;

    // Frame FSM: address capture, pad counting and payload shifting
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      shift_d = shift_q;
      first_d = first_q;
      done_c  = 1'b0;
      last_c  = 1'b0;
      proto_c = 1'b0;
      word_c  = (shift_q >> 1) | (DATA_W'(din[p]) << (DATA_W - 1));
      unique case (state_q)
        S_IDLE: begin
          if (!frame_n[p]) begin
            addr_d  = ADDR_W'(din[p]) << (ADDR_W - 1);
            first_d = 1'b1;
            if (ADDR_W == 1) begin
              state_d = S_PAD;
              cnt_d   = '0;
            end else begin
              state_d = S_ADDR;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        S_ADDR: begin
          if (!valid_n[p] || frame_n[p]) begin
            proto_c = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            addr_d = (addr_q >> 1) | (ADDR_W'(din[p]) << (ADDR_W - 1));
            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
              state_d = S_PAD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_PAD: begin
          if (!valid_n[p] || frame_n[p]) begin
            proto_c = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(PAD_CYCLES - 1)) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (!valid_n[p]) begin
            shift_d = word_c;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              done_c  = 1'b1;
              first_d = 1'b0;
              cnt_d   = '0;
              if (frame_n[p]) begin
                last_c  = 1'b1;
                state_d = S_IDLE;
              end
            end else if (frame_n[p]) begin
              proto_c = 1'b1;
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (frame_n[p]) begin
            proto_c = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Holding register, backpressure and sticky error bits
    always_comb begin
      valid_d     = valid_q;
      data_d      = data_q;
      dst_d       = dst_q;
      sop_d       = sop_q;
      eop_d       = eop_q;
      err_ovf_d   = err_clr ? 1'b0 : err_ovf_q;
      err_proto_d = err_clr ? 1'b0 : err_proto_q;
      busy_n_d    = !(valid_q && !word_ready[p]);
      if (valid_q && word_ready[p]) begin
        valid_d = 1'b0;
      end
      if (done_c) begin
        if (!valid_q || word_ready[p]) begin
          valid_d = 1'b1;
          data_d  = word_c;
          dst_d   = addr_q;
          sop_d   = first_q;
          eop_d   = last_c;
        end else begin
          err_ovf_d = 1'b1;
        end
      end
      if (proto_c) begin
        err_proto_d = 1'b1;
      end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        addr_q      <= '0;
        shift_q     <= '0;
        first_q     <= 1'b0;
        valid_q     <= 1'b0;
        data_q      <= '0;
        dst_q       <= '0;
        sop_q       <= 1'b0;
        eop_q       <= 1'b0;
        busy_n_q    <= 1'b1;
        err_proto_q <= 1'b0;
        err_ovf_q   <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        addr_q      <= addr_d;
        shift_q     <= shift_d;
        first_q     <= first_d;
        valid_q     <= valid_d;
        data_q      <= data_d;
        dst_q       <= dst_d;
        sop_q       <= sop_d;
        eop_q       <= eop_d;
        busy_n_q    <= busy_n_d;
        err_proto_q <= err_proto_d;
        err_ovf_q   <= err_ovf_d;
      end
    end

    assign busy_n[p]                     = busy_n_q;
    assign word_valid[p]                 = valid_q;
    assign word_data[p*DATA_W +: DATA_W] = data_q;
    assign word_dst[p*ADDR_W +: ADDR_W]  = dst_q;
    assign word_sop[p]                   = sop_q;
    assign word_eop[p]                   = eop_q;
    assign err_proto[p]                  = err_proto_q;
    assign err_ovf[p]                    = err_ovf_q;
  end

endmodule

// File: tb/tb_router_port_rx.sv
// Directed self-checking bench for router_port_rx (default parameters).
module tb_router_port_rx;

  localparam int unsigned NP = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NP-1:0]     frame_n;
  logic [NP-1:0]     valid_n;
  logic [NP-1:0]     din;
  logic [NP-1:0]     busy_n;
  logic [NP-1:0]     word_valid;
  logic [NP-1:0]     word_ready;
  logic [NP*DW-1:0]  word_data;
  logic [NP*AW-1:0]  word_dst;
  logic [NP-1:0]     word_sop;
  logic [NP-1:0]     word_eop;
  logic              err_clr;
  logic [NP-1:0]     err_proto;
  logic [NP-1:0]     err_ovf;

  int total = 0;
  int bad   = 0;

  router_port_rx #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PAD_CYCLES(5)) dut (
    .clk(clk), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .din(din),
    .busy_n(busy_n), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_dst(word_dst), .word_sop(word_sop), .word_eop(word_eop),
    .err_clr(err_clr), .err_proto(err_proto), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Watchdog against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on port p; every other port idles
  task automatic drive(input int p, input logic f, input logic v, input logic d);
    frame_n    = '1;
    valid_n    = '1;
    din        = '0;
    frame_n[p] = f;
    valid_n[p] = v;
    din[p]     = d;
    tick();
  endtask

  // Full frame on port p with optional gap before payload bit gap_bit of word 0
  task automatic send_frame(input int p, input logic [3:0] addr, input logic [7:0] w0,
                            input logic [7:0] w1, input int nw, input int gap_bit,
                            input int gap_len, input bit chk_on, input int exp_lat);
    logic [7:0] w;
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      drive(p, 1'b0, 1'b1, addr[i]);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(p, 1'b0, 1'b1, 1'b1);
      n++;
    end
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int b = 0; b < 8; b++) begin
        if (k == 0 && b == gap_bit) begin
          for (int g = 0; g < gap_len; g++) begin
            drive(p, 1'b0, 1'b1, 1'b0);
            n++;
          end
        end
        if (b == 7 && chk_on) chk("pre_valid", 128'(word_valid[p]), 128'd0);
        drive(p, (k == nw - 1 && b == 7) ? 1'b1 : 1'b0, 1'b0, w[b]);
        n++;
      end
      if (chk_on) begin
        if (k == 0) chk("latency", 128'(n), 128'(exp_lat));
        chk("valid", 128'(word_valid[p]), 128'd1);
        chk("data", 128'(word_data[p*DW +: DW]), 128'(w));
        chk("dst", 128'(word_dst[p*AW +: AW]), 128'(addr));
        chk("sop", 128'(word_sop[p]), (k == 0) ? 128'd1 : 128'd0);
        chk("eop", 128'(word_eop[p]), (k == nw - 1) ? 128'd1 : 128'd0);
      end
    end
    frame_n = '1;
    valid_n = '1;
    din     = '0;
  endtask

  logic [3:0] a0, a15;
  logic [7:0] d0, d15;

  initial begin
    reset_n    = 1'b0;
    frame_n    = '1;
    valid_n    = '1;
    din        = '0;
    word_ready = '1;
    err_clr    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_valid", 128'(word_valid), 128'd0);
    chk("rst_busy", 128'(busy_n), 128'hFFFF);
    chk("rst_proto", 128'(err_proto), 128'd0);
    chk("rst_ovf", 128'(err_ovf), 128'd0);
    chk("rst_data", word_data, 128'd0);

    // Two-word frame on port 3
    send_frame(3, 4'hA, 8'h5C, 8'h81, 2, -1, 0, 1'b1, 17);
    tick();
    chk("t1_drain", 128'(word_valid), 128'd0);

    // Same frame with a 3-cycle gap before payload bit 4
    send_frame(3, 4'hA, 8'h5C, 8'h81, 2, 4, 3, 1'b1, 20);
    tick();

    // Overflow on port 0 with downstream stalled
    word_ready[0] = 1'b0;
    send_frame(0, 4'h2, 8'h11, 8'h22, 2, -1, 0, 1'b0, 0);
    chk("ovf_valid", 128'(word_valid[0]), 128'd1);
    chk("ovf_data", 128'(word_data[7:0]), 128'h11);
    chk("ovf_dst", 128'(word_dst[3:0]), 128'h2);
    chk("ovf_sop", 128'(word_sop[0]), 128'd1);
    chk("ovf_flag", 128'(err_ovf), 128'h0001);
    chk("ovf_busy", 128'(busy_n[0]), 128'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", 128'(err_ovf), 128'd0);
    chk("ovf_hold", 128'(word_data[7:0]), 128'h11);
    word_ready[0] = 1'b1;
    tick();
    chk("ovf_xfer", 128'(word_valid[0]), 128'd0);
    chk("ovf_busy_rel", 128'(busy_n[0]), 128'd1);

    // frame_n rises during pad on port 7
    for (int i = 0; i < 4; i++) drive(7, 1'b0, 1'b1, 1'b1);
    drive(7, 1'b0, 1'b1, 1'b0);
    drive(7, 1'b0, 1'b1, 1'b0);
    drive(7, 1'b1, 1'b1, 1'b0);
    chk("pad_proto", 128'(err_proto), 128'h0080);
    chk("pad_novalid", 128'(word_valid), 128'd0);
    drive(7, 1'b1, 1'b1, 1'b0);
    send_frame(7, 4'h6, 8'h3C, 8'h00, 1, -1, 0, 1'b1, 17);
    chk("pad_sticky", 128'(err_proto[7]), 128'd1);

    // Error event on the same cycle as err_clr: error wins
    drive(4, 1'b0, 1'b1, 1'b1);
    err_clr = 1'b1;
    drive(4, 1'b1, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("clr_vs_err", 128'(err_proto), 128'h0010);
    err_clr = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("clr_all", 128'(err_proto), 128'd0);

    // Simultaneous frames on ports 0 and 15
    a0 = 4'h3; a15 = 4'hC; d0 = 8'hAA; d15 = 8'h55;
    for (int i = 0; i < 17; i++) begin
      frame_n = '1;
      valid_n = '1;
      din     = '0;
      if (i < 4) begin
        frame_n[0] = 1'b0; frame_n[15] = 1'b0;
        din[0] = a0[i]; din[15] = a15[i];
      end else if (i < 9) begin
        frame_n[0] = 1'b0; frame_n[15] = 1'b0;
      end else begin
        frame_n[0]  = (i == 16) ? 1'b1 : 1'b0;
        frame_n[15] = (i == 16) ? 1'b1 : 1'b0;
        valid_n[0] = 1'b0; valid_n[15] = 1'b0;
        din[0] = d0[i-9]; din[15] = d15[i-9];
      end
      tick();
    end
    frame_n = '1; valid_n = '1; din = '0;
    chk("dual_valid", 128'(word_valid), 128'h8001);
    chk("dual_data0", 128'(word_data[7:0]), 128'hAA);
    chk("dual_data15", 128'(word_data[127:120]), 128'h55);
    chk("dual_dst0", 128'(word_dst[3:0]), 128'h3);
    chk("dual_dst15", 128'(word_dst[63:60]), 128'hC);
    chk("dual_sop", 128'(word_sop & 16'h8001), 128'h8001);
    chk("dual_eop", 128'(word_eop & 16'h8001), 128'h8001);
    tick();

    // Reset mid-payload on port 2, with a stalled word held on port 9
    word_ready[9] = 1'b0;
    send_frame(9, 4'h4, 8'h77, 8'h00, 1, -1, 0, 1'b1, 17);
    tick();
    chk("pre_rst_busy9", 128'(busy_n[9]), 128'd0);
    for (int i = 0; i < 13; i++) drive(2, 1'b0, (i < 9) ? 1'b1 : 1'b0, 1'b1);
    reset_n = 1'b0;
    drive(2, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    word_ready = '1;
    chk("mrst_valid", 128'(word_valid), 128'd0);
    chk("mrst_busy", 128'(busy_n), 128'hFFFF);
    chk("mrst_data", word_data, 128'd0);
    chk("mrst_dst", 128'(word_dst), 128'd0);
    chk("mrst_sop", 128'(word_sop), 128'd0);
    chk("mrst_eop", 128'(word_eop), 128'd0);
    chk("mrst_err", 128'({err_proto, err_ovf}), 128'd0);
    drive(2, 1'b1, 1'b1, 1'b0);
    send_frame(2, 4'h1, 8'hFF, 8'h00, 1, -1, 0, 1'b1, 17);
    tick();
    chk("final_err", 128'({err_proto, err_ovf}), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
